// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-fill controller.
//   fill_state_e   : controller state encoding (IDLE=0, FILL=1)
//   LINE_WORDS     : default number of 16-bit words per cache line
//   OFFSET_W       : word-index width within a line
//   line_base_mask : byte-address mask that clears the offset-within-line bits
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned OFFSET_W   = $clog2(LINE_WORDS);
  localparam int unsigned DATA_W     = 16;

  // A line spans 2*line_words bytes. This must be a power of two, so the
  // low bits of the byte address are the offset and the rest is the line base.
  function automatic logic [31:0] line_base_mask(int unsigned line_words);
    return ~(32'(line_words * 2) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of CPU-miss, memory-request, memory-return and array-write signals
// for the line-fill controller.
//   slave  : the fill controller (takes misses and memory data, drives
//            requests, array write strobes and busy)
//   master : the environment (CPU lookup, memory, data/tag arrays)
interface cache_fill_fsm_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_WORDS = 8
);
  localparam int unsigned OFS_W = $clog2(LINE_WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              write_data_array;
  logic [OFS_W-1:0]  fill_offset;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address,
           write_data_array, fill_offset, fill_data, write_tag_array
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address,
           write_data_array, fill_offset, fill_data, write_tag_array
  );
endinterface

// File: rtl/fill_counter.sv
// Saturating word counter for one cache-line fill.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart at zero (takes priority over enable)
//   enable   : count one word this cycle
//   count    : current count, 0..LINE_WORDS
//   done     : count has reached LINE_WORDS; further enables are ignored
module fill_counter #(
  parameter  int unsigned LINE_WORDS = 8,
  localparam int unsigned CNT_W      = $clog2(LINE_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == CNT_W'(LINE_WORDS));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache line-fill controller. On a miss it latches the line base, issues one
// memory read per cycle for every word of the line, and writes each returned
// word into the data array in arrival order. The last word also writes the
// tag. Memory latency is unknown, so returns are counted, never matched.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_fill_fsm_if.slave (miss in, memory request/return,
//              data/tag array write strobes, fsm_busy stall)
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_WORDS = cache_pkg::LINE_WORDS
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.slave bus
);

  localparam int unsigned OFS_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = OFS_W + 1;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  req_cnt, rcv_cnt;
  logic              req_done, rcv_done;
  logic              start, req_en, rcv_en;

  // Word address of the next request; each word is two bytes.
  assign req_addr = base_q + (ADDR_W'(req_cnt) << 1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_hold_d = addr_hold_q;
    start       = 1'b0;
    req_en      = 1'b0;
    rcv_en      = 1'b0;

    bus.mem_read_en      = 1'b0;
    bus.memory_address   = addr_hold_q;
    bus.write_data_array = 1'b0;
    bus.fill_offset      = '0;
    bus.write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Returns arriving here are stale (e.g. after a reset) and dropped.
        if (bus.miss_detected) begin
          start   = 1'b1;
          base_d  = bus.miss_address & ADDR_W'(line_base_mask(LINE_WORDS));
          state_d = FILL;
        end
      end
      FILL: begin
        // Issue and receive are independent and may happen in the same cycle.
        if (!req_done) begin
          req_en             = 1'b1;
          bus.mem_read_en    = 1'b1;
          bus.memory_address = req_addr;
          addr_hold_d        = req_addr;
        end
        if (bus.memory_data_valid && !rcv_done) begin
          rcv_en               = 1'b1;
          bus.write_data_array = 1'b1;
          bus.fill_offset      = rcv_cnt[OFS_W-1:0];
          if (rcv_cnt == CNT_W'(LINE_WORDS - 1)) begin
            // Tag goes in with the final word; a miss this cycle is ignored.
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign bus.fsm_busy  = (state_q == FILL);
  assign bus.fill_data = bus.memory_data;

  fill_counter #(.LINE_WORDS(LINE_WORDS)) u_req_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (req_en),
    .count  (req_cnt),
    .done   (req_done)
  );

  fill_counter #(.LINE_WORDS(LINE_WORDS)) u_rcv_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (rcv_en),
    .count  (rcv_cnt),
    .done   (rcv_done)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int LW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LW)) bus ();

  cache_fill_fsm #(.ADDR_W(ADDR_W), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory content: a fixed scramble of the word address.
  function automatic logic [15:0] mem_word(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct {
    logic [2:0]  ofs;
    logic [15:0] data;
    bit          last;
  } wr_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];

  int cyc         = 0;
  bit model_busy  = 0;
  int model_rcv   = 0;
  int accept_cnt  = 0;
  int accept_cyc  = 0;
  int req_idx     = 0;
  int wr_idx      = 0;
  int tag_cnt     = 0;
  int tag_rel     = 0;
  int first_req_cyc = 0;
  bit var_lat     = 0;
  bit spur        = 0;

  // A fill is a line of LW words; it is accepted at an edge where the
  // controller is idle and a miss is present, and it ends at the edge where
  // the LW-th memory word of that fill has been delivered.
  always @(posedge clk) begin
    logic [15:0] base;
    cyc++;
    if (rst) begin
      model_busy = 0;
      model_rcv  = 0;
      exp_req.delete();
      exp_wr.delete();
    end else if (model_busy) begin
      if (bus.memory_data_valid) begin
        model_rcv++;
        if (model_rcv == LW) model_busy = 0;
      end
    end else if (bus.miss_detected) begin
      base = bus.miss_address & ~16'(2 * LW - 1);
      for (int i = 0; i < LW; i++) begin
        exp_req.push_back(base + 16'(2 * i));
        exp_wr.push_back('{ofs: 3'(i), data: mem_word(base + 16'(2 * i)), last: (i == LW - 1)});
      end
      model_busy = 1;
      model_rcv  = 0;
      accept_cnt++;
      accept_cyc = cyc;
      req_idx    = 0;
      wr_idx     = 0;
    end
  end

  // ---------------- memory: pipelined, 4-cycle base latency ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  always @(negedge clk) begin
    if (!rst && bus.mem_read_en) mq.push_back('{addr: bus.memory_address, due: cyc + 4});
  end

  initial begin
    int gap;
    gap = 0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0;
      if (gap > 0) begin
        gap--;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = mem_word(mq[0].addr);
        void'(mq.pop_front());
        gap = var_lat ? int'($urandom_range(0, 3)) : 0;
      end else if (spur) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'hBEEF;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int  rel;
    wr_t w;
    if (!rst) begin
      rel = cyc - accept_cyc + 1;
      check("busy", 32'(bus.fsm_busy), 32'(model_busy));
      if (exp_req.size() == 0) begin
        check("stray_req", 32'(bus.mem_read_en), 0);
      end else if (bus.mem_read_en) begin
        if (req_idx == 0) first_req_cyc = cyc;
        check("req_addr", 32'(bus.memory_address), 32'(exp_req.pop_front()));
        check("req_cycle", rel, req_idx + 1);
        req_idx++;
      end
      if (exp_wr.size() == 0) begin
        check("stray_wr", 32'(bus.write_data_array), 0);
      end else if (bus.write_data_array) begin
        w = exp_wr.pop_front();
        check("fill_offset", 32'(bus.fill_offset), 32'(w.ofs));
        check("fill_data", 32'(bus.fill_data), 32'(w.data));
        check("tag_with_word", 32'(bus.write_tag_array), 32'(w.last));
        if (!var_lat) check("wr_cycle", rel, wr_idx + 5);
        wr_idx++;
      end
      if (!bus.write_data_array) check("tag_alone", 32'(bus.write_tag_array), 0);
      if (bus.write_tag_array) begin
        tag_cnt++;
        tag_rel = rel;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((model_busy || mq.size() > 0 || bus.memory_data_valid) && n < 300) begin
      tick();
      n++;
    end
    check("quiet_timeout", 32'(n < 300), 1);
  endtask

  task automatic do_miss(logic [15:0] addr);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    tick();
    bus.miss_detected = 1'b0;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_busy"}, 32'(bus.fsm_busy), 0);
    check({tag, "_rd"}, 32'(bus.mem_read_en), 0);
    check({tag, "_wr"}, 32'(bus.write_data_array), 0);
    check({tag, "_tag"}, 32'(bus.write_tag_array), 0);
    check({tag, "_addr"}, 32'(bus.memory_address), 0);
    check({tag, "_ofs"}, 32'(bus.fill_offset), 0);
  endtask

  initial begin
    int busy_cycles, e1, n, tags_before;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Basic fill at 0x1236 with fixed 4-cycle memory.
    var_lat = 0;
    wait_quiet();
    tags_before = tag_cnt;
    do_miss(16'h1236);
    busy_cycles = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.fsm_busy) busy_cycles++;
    end
    tick();
    check("basic_busy_cycles", busy_cycles, 12);
    check("basic_tag_cycle", tag_rel, 12);
    check("basic_tag_count", tag_cnt - tags_before, 1);
    $display("fill 0x1236 basic done, vectors=%0d", vectors);

    // Back-to-back fills with miss held high.
    wait_quiet();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0010;
    tick();
    e1 = accept_cyc;
    n  = accept_cnt;
    bus.miss_address = 16'h0020;
    begin
      int k;
      k = 0;
      while (accept_cnt < n + 1 && k < 40) begin
        tick();
        k++;
      end
      check("b2b_timeout", 32'(k < 40), 1);
    end
    bus.miss_detected = 1'b0;
    wait_quiet();
    check("b2b_first_req_cycle", first_req_cyc - e1 + 1, 14);
    $display("fill 0x0010/0x0020 back-to-back done, vectors=%0d", vectors);

    // Spurious memory valid while idle.
    spur = 1;
    repeat (4) begin
      @(negedge clk);
      check("spur_wr", 32'(bus.write_data_array), 0);
      check("spur_busy", 32'(bus.fsm_busy), 0);
    end
    tick();
    spur = 0;
    tick();
    $display("spurious valid 0xBEEF done, vectors=%0d", vectors);

    // Reset after three words of a fill, then a fresh fill at 0xFFF0.
    wait_quiet();
    tags_before = tag_cnt;
    do_miss(16'h2468);
    n = 0;
    while (wr_idx < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_wait_timeout", 32'(n < 50), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    check_outputs_zero("held_rst");
    rst = 1'b0;
    wait_quiet();
    check("rst_no_tag", tag_cnt - tags_before, 0);
    do_miss(16'hFFF0);
    wait_quiet();
    check("post_rst_tag", tag_cnt - tags_before, 1);
    $display("reset mid-fill, refill 0xFFF0 done, vectors=%0d", vectors);

    // Address changes during the fill at 0x4000 must not leak into requests.
    do_miss(16'h4000);
    repeat (12) begin
      bus.miss_address = ($urandom_range(0, 1) != 0) ? 16'hAAAA : 16'h5555;
      tick();
    end
    wait_quiet();
    $display("fill 0x4000 with address toggling done, vectors=%0d", vectors);

    // Randomized fills: random lines, random return gaps, random misses
    // arriving while busy.
    for (int f = 0; f < 20; f++) begin
      wait_quiet();
      var_lat = (f < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      tags_before = tag_cnt;
      do_miss(16'($urandom));
      repeat (10) begin
        bus.miss_detected = ($urandom_range(0, 3) == 0);
        bus.miss_address  = 16'($urandom);
        tick();
      end
      bus.miss_detected = 1'b0;
      wait_quiet();
      check("rand_tag_written", 32'(tag_cnt > tags_before), 1);
      $display("random fill %0d var_lat=%0d tags=%0d vectors=%0d", f, var_lat, tag_cnt - tags_before, vectors);
    end
    check("queues_drained", 32'(exp_req.size() + exp_wr.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of CPU and memory.
REQ-002 Parameter LINE_WORDS, default 8, 16-bit words per cache line; SHALL be a power of two.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 miss_detected  input  1  cache lookup missed this cycle.
REQ-006 miss_address  input  ADDR_W  byte address that missed.
REQ-007 fsm_busy  output  1  fill in progress; CPU stalls pc and pipeline while high.
REQ-008 mem_read_en  output  1  read request to multi-cycle memory this cycle.
REQ-009 memory_address  output  ADDR_W  byte address of the current memory request.
REQ-010 memory_data_valid  input  1  memory returns one word this cycle.
REQ-011 memory_data  input  16  returned word.
REQ-012 write_data_array  output  1  write fill_data into the data array at fill_offset this cycle.
REQ-013 fill_offset  output  log2(LINE_WORDS)  word index within the line for the data-array write.
REQ-014 fill_data  output  16  memory_data passed through combinationally.
REQ-015 write_tag_array  output  1  write the tag/valid for the latched line this cycle.

Function
REQ-016 Two states: IDLE, FILL; fsm_busy SHALL equal (state == FILL), Moore, no combinational path from miss_detected.
REQ-017 IDLE with miss_detected=1 at a rising edge: latch base = {miss_address[ADDR_W-1:4], 4'b0} (for LINE_WORDS=8), clear req_cnt and rcv_cnt, enter FILL.
REQ-018 In FILL, while req_cnt < LINE_WORDS: mem_read_en=1, memory_address = base + 2*req_cnt, req_cnt increments each cycle; one request per cycle, no gaps.
REQ-019 In FILL, once req_cnt == LINE_WORDS, mem_read_en=0 and memory_address holds its last value.
REQ-020 Memory is pipelined, fixed latency unknown to this block; returned words are counted, never matched by address.
REQ-021 In FILL with memory_data_valid=1: write_data_array=1, fill_offset = rcv_cnt, rcv_cnt increments.
REQ-022 The valid that brings rcv_cnt from LINE_WORDS-1 to LINE_WORDS SHALL also assert write_tag_array in the same cycle; next state IDLE.
REQ-023 Issue and receive in the same cycle SHALL both proceed independently.
REQ-024 miss_detected while in FILL, including the final tag-write cycle, SHALL be ignored; if still asserted in the next IDLE cycle, a new fill starts.
REQ-025 Changes to miss_address after acceptance SHALL NOT affect the fill in progress.
REQ-026 memory_data_valid in IDLE SHALL be ignored: no write strobes, no counter change.
REQ-027 Counters are log2(LINE_WORDS)+1 bits wide; no wrap within a fill.
REQ-028 With a 4-cycle memory and LINE_WORDS=8: miss sampled at edge 0; requests in cycles 1-8; data in cycles 5-12; tag write in cycle 12; fsm_busy low from cycle 13.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, counters 0, base 0, independent of clk.
REQ-030 During and after reset: fsm_busy, mem_read_en, write_data_array and write_tag_array SHALL be 0; memory_address and fill_offset SHALL be 0.
REQ-031 Reset during FILL SHALL abandon the line with no tag write; late memory_data_valid after reset SHALL be ignored per REQ-026.

Structure
REQ-032 Shared package cache_pkg holds the state encoding (IDLE=0, FILL=1), LINE_WORDS, OFFSET_W=log2(LINE_WORDS), and the line-base mask helper.
REQ-033 One sub-module, fill_counter (enable, clear, count, done at LINE_WORDS), instantiated twice: request counter and receive counter.

Verification
REQ-034 Basic fill: miss at 0x1236 with 4-cycle memory -> requests 0x1230, 0x1232 ... 0x123E in cycles 1-8; offsets 0-7 written in cycles 5-12; write_tag_array in cycle 12 only; fsm_busy high in cycles 1-12.
REQ-035 Back-to-back: miss_detected held high through the fill at 0x0010 then 0x0020 -> second fill's first request in cycle 14, no overlap of strobes.
REQ-036 Spurious valid: memory_data_valid=1 in IDLE with data 0xBEEF -> no write strobes, fsm_busy stays 0.
REQ-037 Reset mid-fill: rst pulse after 3 words received -> all outputs 0 asynchronously, no tag write; new miss at 0xFFF0 fills 0xFFF0-0xFFFE correctly.
REQ-038 Variable latency: memory returns the 8 words with random 0-3 cycle gaps -> offsets still 0-7 in order, tag write coincides with the 8th valid.
REQ-039 Address change: miss_address toggled to 0xAAAA during the fill at 0x4000 -> all requests stay in 0x4000-0x400E.
